rv_alu_md: RTL and testbench
============================

Name: rv_alu_md

Overview:
- Parametrised-width RISC-V execute unit: single-cycle base integer ALU ops (RV32I/RV64I funct3 set) plus an iterative M-extension multiply/divide engine.
- Sits in the EX stage. Decode supplies funct3, the sub/sign flags and an M-select flag.
- A valid/ready handshake lets the pipeline stall while a multiply or divide is in progress.
- Outputs are registered, like the existing single-cycle ALU.

Parameters:
- XLEN, 32, datapath width; power of two, at least 8.
- MD_EN, 1, 1 = M-extension engine present; 0 = i_fMulDiv ignored and all ops take the base path.

Ports:
- i_Clk  in  1  clock; all logic on the rising edge
- i_Rst  in  1  synchronous active-low reset
- i_Valid  in  1  operation request
- o_Ready  out  1  unit can accept; high only in IDLE
- i_fMulDiv  in  1  1 = M-extension op (funct7 = 0000001)
- i_Op  in  3  funct3
- i_fSub  in  1  subtract for ADD/SUB, SLT/SLTU and branches
- i_fSign  in  1  arithmetic right shift (SRA/SRAI)
- i_Data0, i_Data1  in  XLEN  rs1 and rs2/imm operands
- o_Valid  out  1  result valid, one-cycle pulse
- o_Data  out  XLEN  result
- o_fBranch  out  1  branch condition (base ops only)
- o_fNeg  out  1  sign/borrow bit of the (XLEN+1)-bit add/sub

Behaviour:
- Reset (i_Rst=0 at a clock edge):
  - state=IDLE; counter, accumulators, o_Data, o_fBranch, o_fNeg and o_Valid all 0.
  - o_Ready=1 from the next cycle.
  - Reset mid-operation aborts the operation; no o_Valid is produced for it.
- Accept: when i_Valid && o_Ready at edge N. Operands and control are latched at acceptance. i_Valid while not ready is ignored, not queued.
- Base path (i_fMulDiv=0 or MD_EN=0): latency 1; o_Valid=1 and results registered at edge N+1; back-to-back accepts allowed every cycle.
  - Adder: {ext,Data0} ± {ext,Data1}, XLEN+1 bits.
    - ext = operand MSB for signed ops; 0 when i_Op is 3, 6 or 7 (unsigned ops).
    - o_fNeg = bit XLEN of the sum.
  - funct3 results:
    - 0 ADD/SUB.
    - 1 SLL.
    - 2/3 SLT/SLTU = zero-extended o_fNeg; the controller asserts i_fSub.
    - 4 XOR.
    - 5 SRL/SRA, sign-filled when i_fSign.
    - 6 OR.
    - 7 AND.
  - Shift amount = i_Data1[log2(XLEN)-1:0].
  - o_fBranch by funct3:
    - 0 zero, 1 !zero.
    - 4 and 6 neg; 5 and 7 !neg.
    - 2 and 3 give 0.
- M path: funct3 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  - o_fBranch=0 and o_fNeg=0 on M results.
  - FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL or DIV on accept. Operand magnitudes are taken per signedness; the result sign is recorded; the counter is loaded with XLEN.
  - MUL: radix-2 shift-add over a 2·XLEN product, one bit per cycle.
  - DIV: restoring shift-subtract, one quotient bit per cycle.
  - After XLEN iterations: →DONE, sign correction applied (two's complement if negative).
  - DONE: result registered, o_Valid=1, →IDLE.
  - Result at edge N+XLEN+1. o_Ready=0 from cycle N+1 through N+XLEN+1.
  - Sign rules:
    - MULHSU: Data0 signed, Data1 unsigned.
    - Remainder takes the sign of the dividend.
    - Quotient sign = XOR of the operand signs.
  - MUL returns the low half of the product; MULH* return the high half.
- Special cases (fast path, no FSM, latency 1 like the base path):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → Data0.
  - Signed overflow (Data0 = most-negative, Data1 = -1): DIV → most-negative; REM → 0.
- o_Data holds its last value when o_Valid=0.

Test Plan:
- ADD, XLEN=32: 0x7FFFFFFF + 1 → o_Data=0x80000000, o_fNeg=0, o_Valid at N+1. SUB with Data0=0, Data1=1 → 0xFFFFFFFF, o_fNeg=1.
- SRA: 0x80000000 >> 4 with i_fSign=1 → 0xF8000000. SRL → 0x08000000. BLTU with Data0=1, Data1=0xFFFFFFFF, i_fSub=1 → o_fBranch=1. BLT with the same operands → o_fBranch=0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE at exactly N+33; o_Ready low N+1..N+33; a concurrent i_Valid pulse at N+5 is ignored. MUL 0xFFFFFFFF × 2 → 0xFFFFFFFE. MULH -1 × -1 → 0.
- DIV -7 / 2 → 0xFFFFFFFD. REM -7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2. Each valid at N+33.
- DIVU 7 / 0 → 0xFFFFFFFF and REMU 7 / 0 → 7, both at N+1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, both at N+1.
- Reset asserted at N+10 of a DIV → outputs 0, o_Valid never pulses, o_Ready=1 after reset; a following ADD 3 + 4 → 7 at +1. Repeat the ADD test with XLEN=64, MD_EN=0: i_fMulDiv=1 with funct3=0 → result is ADD.

Source files
------------

// File: rtl/rv_alu_md.sv
// rv_alu_md: RISC-V EX-stage integer ALU with an iterative M-extension engine.
// Base ops and divide corner cases take one cycle; MUL/DIV resolve one bit per cycle.
module rv_alu_md #(
   parameter int XLEN  = 32,
   parameter int MD_EN = 1
) (
   input  logic            i_Clk,
   input  logic            i_Rst,
   input  logic            i_Valid,
   output logic            o_Ready,
   input  logic            i_fMulDiv,
   input  logic [2:0]      i_Op,
   input  logic            i_fSub,
   input  logic            i_fSign,
   input  logic [XLEN-1:0] i_Data0,
   input  logic [XLEN-1:0] i_Data1,
   output logic            o_Valid,
   output logic [XLEN-1:0] o_Data,
   output logic            o_fBranch,
   output logic            o_fNeg
);

   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;
   localparam int PW = 2 * XLEN;
   localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   prod_q, prod_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic            rneg_q, rneg_d;
   logic            hi_q, hi_d;
   logic            isdiv_q, isdiv_d;
   logic            pend_q, pend_d;
   logic            spc_q, spc_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic            sub_q, sub_d;
   logic            sgn_q, sgn_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            br_q, br_d;
   logic            fneg_q, fneg_d;
   logic            valid_q, valid_d;

   logic            accept, md_sel;
   logic            a_sg, b_sg, in_bz, in_ovf, in_spc;
   logic [XLEN-1:0] mag_a, mag_b;

   logic            uns, zf;
   logic [XLEN:0]   opa, opb, sum, shr;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] base_res, spec_res;
   logic            base_br;

   logic [XLEN:0]   mul_hi, div_top, div_diff;
   logic            div_ge;
   logic [PW-1:0]   full;
   logic [XLEN-1:0] part, fin;

   assign o_Ready   = (state_q == S_IDLE);
   assign o_Valid   = valid_q;
   assign o_Data    = data_q;
   assign o_fBranch = br_q;
   assign o_fNeg    = fneg_q;

   // Decode the incoming request: signedness, magnitudes and divide corner cases.
   always_comb begin
      accept = i_Valid && (state_q == S_IDLE);
      md_sel = (MD_EN != 0) && i_fMulDiv;
      a_sg   = i_Data0[XLEN-1] &
               ((i_Op == 3'd1) || (i_Op == 3'd2) ||
                (i_Op == 3'd4) || (i_Op == 3'd6));
      b_sg   = i_Data1[XLEN-1] &
               ((i_Op == 3'd1) || (i_Op == 3'd4) || (i_Op == 3'd6));
      mag_a  = a_sg ? -i_Data0 : i_Data0;
      mag_b  = b_sg ? -i_Data1 : i_Data1;
      in_bz  = (i_Data1 == '0);
      in_ovf = (i_Data0 == MINV) && (i_Data1 == '1) &&
               i_Op[2] && !i_Op[0];
      in_spc = md_sel && i_Op[2] && (in_bz || in_ovf);
   end

   // Single-cycle datapath evaluated on the operands latched at acceptance.
   always_comb begin
      uns      = (op_q == 3'd3) || (op_q[2:1] == 2'b11);
      opa      = {~uns & a_q[XLEN-1], a_q};
      opb      = {~uns & b_q[XLEN-1], b_q} ^ {(XLEN+1){sub_q}};
      sum      = opa + opb + (XLEN+1)'(sub_q);
      shamt    = b_q[SW-1:0];
      shr      = $signed({sgn_q & a_q[XLEN-1], a_q}) >>> shamt;
      zf       = (sum[XLEN-1:0] == '0);
      base_res = '0;
      base_br  = 1'b0;
      unique case (op_q)
         3'd0: begin base_res = sum[XLEN-1:0];          base_br = zf;        end
         3'd1: begin base_res = a_q << shamt;           base_br = !zf;       end
         3'd2: begin base_res = XLEN'(sum[XLEN]);       base_br = 1'b0;      end
         3'd3: begin base_res = XLEN'(sum[XLEN]);       base_br = 1'b0;      end
         3'd4: begin base_res = a_q ^ b_q;              base_br = sum[XLEN]; end
         3'd5: begin base_res = shr[XLEN-1:0];          base_br = !sum[XLEN]; end
         3'd6: begin base_res = a_q | b_q;              base_br = sum[XLEN]; end
         3'd7: begin base_res = a_q & b_q;              base_br = !sum[XLEN]; end
      endcase
      if (b_q == '0) begin
         spec_res = op_q[1] ? a_q : '1;
      end else begin
         spec_res = op_q[1] ? '0 : a_q;
      end
   end

   // One shift-add or shift-subtract step, plus final sign correction.
   always_comb begin
      mul_hi   = {1'b0, prod_q[PW-1:XLEN]} +
                 (prod_q[0] ? {1'b0, mcand_q} : '0);
      div_top  = prod_q[PW-1:XLEN-1];
      div_ge   = (div_top >= {1'b0, mcand_q});
      div_diff = div_top - {1'b0, mcand_q};
      full     = (rneg_q && !isdiv_q) ? -prod_q : prod_q;
      part     = hi_q ? full[PW-1:XLEN] : full[XLEN-1:0];
      fin      = (rneg_q && isdiv_q) ? -part : part;
   end

   // Next-state and output logic for the handshake and the iterative engine.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      isdiv_d = isdiv_q;
      pend_d  = 1'b0;
      spc_d   = spc_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      sub_d   = sub_q;
      sgn_d   = sgn_q;
      data_d  = data_q;
      br_d    = br_q;
      fneg_d  = fneg_q;
      valid_d = 1'b0;

      if (pend_q) begin
         valid_d = 1'b1;
         if (spc_q) begin
            data_d = spec_res;
            br_d   = 1'b0;
            fneg_d = 1'b0;
         end else begin
            data_d = base_res;
            br_d   = base_br;
            fneg_d = sum[XLEN];
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (md_sel && !in_spc) begin
                  state_d = i_Op[2] ? S_DIV : S_MUL;
                  cnt_d   = CW'(XLEN);
                  prod_d  = {{XLEN{1'b0}}, i_Op[2] ? mag_a : mag_b};
                  mcand_d = i_Op[2] ? mag_b : mag_a;
                  rneg_d  = (i_Op[2] && i_Op[1]) ? a_sg : (a_sg ^ b_sg);
                  hi_d    = i_Op[2] ? i_Op[1] : (i_Op[1:0] != 2'b00);
                  isdiv_d = i_Op[2];
               end else begin
                  pend_d = 1'b1;
                  spc_d  = in_spc;
                  a_d    = i_Data0;
                  b_d    = i_Data1;
                  op_d   = i_Op;
                  sub_d  = i_fSub;
                  sgn_d  = i_fSign;
               end
            end
         end
         S_MUL: begin
            prod_d = {mul_hi, prod_q[XLEN-1:1]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DIV: begin
            if (div_ge) begin
               prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            end else begin
               prod_d = {prod_q[PW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            data_d  = fin;
            br_d    = 1'b0;
            fneg_d  = 1'b0;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         rneg_q  <= 1'b0;
         hi_q    <= 1'b0;
         isdiv_q <= 1'b0;
         pend_q  <= 1'b0;
         spc_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         sub_q   <= 1'b0;
         sgn_q   <= 1'b0;
         data_q  <= '0;
         br_q    <= 1'b0;
         fneg_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         isdiv_q <= isdiv_d;
         pend_q  <= pend_d;
         spc_q   <= spc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         sub_q   <= sub_d;
         sgn_q   <= sgn_d;
         data_q  <= data_d;
         br_q    <= br_d;
         fneg_q  <= fneg_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_rv_alu_md.sv
// tb_rv_alu_md: directed checks of rv_alu_md (XLEN=32 with M engine,
// XLEN=64 without).
module tb_rv_alu_md;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v, md, sub, sgn;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        rdy, ov, br, ng;
   logic [31:0] q;

   logic        v64, md64, sub64, sgn64;
   logic [2:0]  op64;
   logic [63:0] a64, b64;
   logic        rdy64, ov64, br64, ng64;
   logic [63:0] q64;

   int          checks = 0;
   int          fails = 0;
   logic [31:0] r_data;
   logic        r_br, r_neg;
   int          r_lat;
   logic        seen;

   rv_alu_md #(.XLEN(32), .MD_EN(1)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Valid(v), .o_Ready(rdy),
      .i_fMulDiv(md), .i_Op(op), .i_fSub(sub), .i_fSign(sgn),
      .i_Data0(a), .i_Data1(b), .o_Valid(ov), .o_Data(q),
      .o_fBranch(br), .o_fNeg(ng)
   );

   rv_alu_md #(.XLEN(64), .MD_EN(0)) dut64 (
      .i_Clk(clk), .i_Rst(rst), .i_Valid(v64), .o_Ready(rdy64),
      .i_fMulDiv(md64), .i_Op(op64), .i_fSub(sub64), .i_fSign(sgn64),
      .i_Data0(a64), .i_Data1(b64), .o_Valid(ov64), .o_Data(q64),
      .o_fBranch(br64), .o_fNeg(ng64)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic f_md, input logic [2:0] f_op,
                        input logic f_sub, input logic f_sgn,
                        input logic [31:0] f_a, input logic [31:0] f_b);
      @(negedge clk);
      md = f_md; op = f_op; sub = f_sub; sgn = f_sgn;
      a = f_a; b = f_b; v = 1'b1;
      @(posedge clk);
      #1 v = 1'b0;
      r_lat = 0;
      do begin
         @(posedge clk);
         #1 r_lat++;
      end while (!ov && r_lat < 40);
      r_data = q;
      r_br   = br;
      r_neg  = ng;
   endtask

   task automatic issue64(input logic f_md, input logic [2:0] f_op,
                          input logic f_sgn, input logic [63:0] f_a,
                          input logic [63:0] f_b);
      @(negedge clk);
      md64 = f_md; op64 = f_op; sub64 = 1'b0; sgn64 = f_sgn;
      a64 = f_a; b64 = f_b; v64 = 1'b1;
      @(posedge clk);
      #1 v64 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; v = 1'b0; md = 1'b0; sub = 1'b0; sgn = 1'b0;
      op = 3'd0; a = '0; b = '0;
      v64 = 1'b0; md64 = 1'b0; sub64 = 1'b0; sgn64 = 1'b0;
      op64 = 3'd0; a64 = '0; b64 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", q, 0);
      chk("rst_flags", {ov, br, ng}, 0);
      chk("rst_ready", rdy, 1);
      chk("rst64_data", q64, 0);
      chk("rst64_flags", {ov64, br64, ng64, rdy64}, 4'b0001);
      @(negedge clk) rst = 1'b1;

      issue(0, 3'd0, 0, 0, 32'h7FFFFFFF, 32'h1);
      chk("add_data", r_data, 32'h80000000);
      chk("add_neg", r_neg, 0);
      chk("add_lat", r_lat, 1);
      issue(0, 3'd0, 1, 0, 32'h0, 32'h1);
      chk("sub_data", r_data, 32'hFFFFFFFF);
      chk("sub_neg", r_neg, 1);
      issue(0, 3'd5, 0, 1, 32'h80000000, 32'h4);
      chk("sra_data", r_data, 32'hF8000000);
      issue(0, 3'd5, 0, 0, 32'h80000000, 32'h4);
      chk("srl_data", r_data, 32'h08000000);
      issue(0, 3'd1, 0, 0, 32'h1, 32'h21);
      chk("sll_mask", r_data, 32'h2);
      issue(0, 3'd2, 1, 0, 32'hFFFFFFFF, 32'h1);
      chk("slt_data", r_data, 32'h1);
      issue(0, 3'd3, 1, 0, 32'hFFFFFFFF, 32'h1);
      chk("sltu_data", r_data, 32'h0);
      issue(0, 3'd6, 1, 0, 32'h1, 32'hFFFFFFFF);
      chk("bltu_br", r_br, 1);
      issue(0, 3'd4, 1, 0, 32'h1, 32'hFFFFFFFF);
      chk("blt_br", r_br, 0);
      issue(0, 3'd0, 1, 0, 32'h5, 32'h5);
      chk("beq_br", r_br, 1);
      issue(0, 3'd1, 1, 0, 32'h5, 32'h5);
      chk("bne_br", r_br, 0);

      @(negedge clk);
      md = 1'b1; op = 3'd3; sub = 1'b0; sgn = 1'b0;
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; v = 1'b1;
      @(posedge clk);
      #1 v = 1'b0;
      chk("mulhu_busy0", {ov, rdy}, 2'b00);
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k == 5) begin
            v = 1'b1; md = 1'b0; op = 3'd0; a = 32'h1; b = 32'h1;
         end else begin
            v = 1'b0;
         end
         @(posedge clk);
         #1;
         if (k < 33) begin
            chk("mulhu_busy", {ov, rdy}, 2'b00);
         end else begin
            chk("mulhu_valid", {ov, rdy}, 2'b11);
            chk("mulhu_data", q, 32'hFFFFFFFE);
            chk("mulhu_flags", {br, ng}, 2'b00);
         end
      end
      @(posedge clk);
      #1 chk("mulhu_pulse", ov, 0);

      issue(1, 3'd0, 0, 0, 32'hFFFFFFFF, 32'h2);
      chk("mul_data", r_data, 32'hFFFFFFFE);
      chk("mul_lat", r_lat, 33);
      issue(1, 3'd1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("mulh_m1", r_data, 32'h0);
      issue(1, 3'd1, 0, 0, 32'h80000000, 32'h80000000);
      chk("mulh_min", r_data, 32'h40000000);
      issue(1, 3'd2, 0, 0, 32'hFFFFFFFF, 32'h2);
      chk("mulhsu", r_data, 32'hFFFFFFFF);

      issue(1, 3'd4, 0, 0, 32'hFFFFFFF9, 32'h2);
      chk("div_data", r_data, 32'hFFFFFFFD);
      chk("div_lat", r_lat, 33);
      issue(1, 3'd6, 0, 0, 32'hFFFFFFF9, 32'h2);
      chk("rem_data", r_data, 32'hFFFFFFFF);
      chk("rem_lat", r_lat, 33);
      issue(1, 3'd5, 0, 0, 32'd100, 32'd7);
      chk("divu_data", r_data, 32'd14);
      chk("divu_lat", r_lat, 33);
      issue(1, 3'd7, 0, 0, 32'd100, 32'd7);
      chk("remu_data", r_data, 32'd2);
      chk("remu_lat", r_lat, 33);

      issue(1, 3'd4, 0, 0, 32'h80000000, 32'hFFFFFFFF);
      chk("div_ovf", r_data, 32'h80000000);
      chk("div_ovf_lat", r_lat, 1);
      issue(1, 3'd6, 0, 0, 32'h80000000, 32'hFFFFFFFF);
      chk("rem_ovf", r_data, 32'h0);
      chk("rem_ovf_lat", r_lat, 1);
      issue(1, 3'd5, 0, 0, 32'd7, 32'd0);
      chk("divu_z", r_data, 32'hFFFFFFFF);
      chk("divu_z_lat", r_lat, 1);
      issue(1, 3'd7, 0, 0, 32'd7, 32'd0);
      chk("remu_z", r_data, 32'd7);
      chk("remu_z_lat", r_lat, 1);

      @(negedge clk);
      md = 1'b1; op = 3'd4; a = 32'hFFFFFFF9; b = 32'h2; v = 1'b1;
      @(posedge clk);
      #1 v = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_data", q, 0);
      chk("abort_flags", {ov, br, ng}, 0);
      chk("abort_ready", rdy, 1);
      @(negedge clk) rst = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 if (ov || !rdy) seen = 1'b1;
      end
      chk("abort_quiet", seen, 0);
      issue(0, 3'd0, 0, 0, 32'd3, 32'd4);
      chk("post_add", r_data, 32'd7);
      chk("post_add_lat", r_lat, 1);

      issue64(1, 3'd0, 0, 64'd3, 64'd4);
      chk("x64_valid", ov64, 1);
      chk("x64_add_md", q64, 64'd7);
      issue64(0, 3'd0, 0, 64'hFFFFFFFF, 64'h1);
      chk("x64_add_wide", q64, 64'h1_0000_0000);
      issue64(0, 3'd5, 1, 64'h8000000000000000, 64'h24);
      chk("x64_sra", q64, 64'hFFFFFFFFF8000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
